msrv32_lu: RTL and testbench



---
 rtl/msrv32_pkg.sv | 10 +
 rtl/msrv32_lu_extract.sv | 46 ++++
 rtl/msrv32_lu.sv | 37 +++
 tb/tb_msrv32_lu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared constants for the MSRV32 core: datapath width and load-size encodings.
package msrv32_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/msrv32_lu_extract.sv
// Combinational byte/halfword/word selection and sign/zero extension for loads.
module msrv32_lu_extract
    import msrv32_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic            load_unsigned_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      offset_i,
    input  logic            resp_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        byteFill;
    logic        halfFill;

    always_comb begin
        byteSel = data_i[7:0];
        case (offset_i)
            2'b00:   byteSel = data_i[7:0];
            2'b01:   byteSel = data_i[15:8];
            2'b10:   byteSel = data_i[23:16];
            default: byteSel = data_i[31:24];
        endcase
    end

    // Offset bit 0 is deliberately ignored: misaligned halfwords fold onto the aligned one.
    assign halfSel  = offset_i[1] ? data_i[31:16] : data_i[15:0];
    assign byteFill = ~load_unsigned_i & byteSel[7];
    assign halfFill = ~load_unsigned_i & halfSel[15];

    always_comb begin
        result_o = data_i;
        if (resp_i) begin
            result_o = '0;
        end else begin
            case (size_i)
                LS_BYTE: result_o = {{(XLEN-8){byteFill}}, byteSel};
                LS_HALF: result_o = {{(XLEN-16){halfFill}}, halfSel};
                default: result_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/msrv32_lu.sv
// MSRV32 load unit: registers the extended load result for register-file write-back.
module msrv32_lu
    import msrv32_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    input  logic [XLEN-1:0] data_in,
    input  logic [1:0]      iadder_1_to_0_in,
    input  logic            ahb_resp_in,
    output logic [XLEN-1:0] lu_output
);

    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;

    msrv32_lu_extract uExtract (
        .size_i          (load_size_in),
        .load_unsigned_i (load_unsigned_in),
        .data_i          (data_in),
        .offset_i        (iadder_1_to_0_in),
        .resp_i          (ahb_resp_in),
        .result_o        (result_d)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign lu_output = result_q;

endmodule

// File: tb/tb_msrv32_lu.sv
// Self-checking bench for msrv32_lu: directed cases plus randomized loads against an arithmetic model.
module tb_msrv32_lu;

    logic        clk_in;
    logic        rst_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] data_in;
    logic [1:0]  iadder_1_to_0_in;
    logic        ahb_resp_in;
    logic [31:0] lu_output;

    int checks = 0;
    int errors = 0;

    msrv32_lu dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .data_in          (data_in),
        .iadder_1_to_0_in (iadder_1_to_0_in),
        .ahb_resp_in      (ahb_resp_in),
        .lu_output        (lu_output)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference: shift the addressed lane down, mask it, then add the sign fill arithmetically.
    function automatic logic [31:0] refModel(input logic [1:0] size, input logic uns,
                                             input logic [31:0] data, input logic [1:0] off,
                                             input logic resp);
        int unsigned v;
        if (resp) return 32'h0;
        if (size >= 2) return data;
        if (size == 0) begin
            v = (data >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (data >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [1:0] size, input logic uns,
                                 input logic [31:0] data, input logic [1:0] off, input logic resp);
        rst_in           = rst;
        load_size_in     = size;
        load_unsigned_in = uns;
        data_in          = data;
        iadder_1_to_0_in = off;
        ahb_resp_in      = resp;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hAABBCCDD, 2'b00, 1'b0);
        checks++;
        if (lu_output !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_cycle1 got %h expected 00000000", lu_output);
        end
        applyStimulus(1'b1, 2'b01, 1'b1, 32'h12345678, 2'b11, 1'b1);
        checks++;
        if (lu_output !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_cycle2 got %h expected 00000000", lu_output);
        end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hAABBCCDD, 2'b01, 1'b0);
        checks++;
        if (lu_output !== 32'hAABBCCDD) begin
            errors++;
            $display("[TB] FAIL reset_preword got %h expected aabbccdd", lu_output);
        end
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hAABBCCDD, 2'b01, 1'b0);
        checks++;
        if (lu_output !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_midstream got %h expected 00000000", lu_output);
        end
    endtask

    task automatic test_byte();
        logic [31:0] expSigned [4] = '{32'hFFFFFFDD, 32'hFFFFFFCC, 32'hFFFFFFBB, 32'hFFFFFFAA};
        logic [31:0] expUnsigned [4] = '{32'h000000DD, 32'h000000CC, 32'h000000BB, 32'h000000AA};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 32'hAABBCCDD, 2'(k), 1'b0);
            checks++;
            if (lu_output !== expSigned[k]) begin
                errors++;
                $display("[TB] FAIL byte_signed_off%0d got %h expected %h", k, lu_output, expSigned[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b00, 1'b1, 32'hAABBCCDD, 2'(k), 1'b0);
            checks++;
            if (lu_output !== expUnsigned[k]) begin
                errors++;
                $display("[TB] FAIL byte_unsigned_off%0d got %h expected %h", k, lu_output, expUnsigned[k]);
            end
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000007F, 2'b00, 1'b0);
        checks++;
        if (lu_output !== 32'h0000007F) begin
            errors++;
            $display("[TB] FAIL byte_positive got %h expected 0000007f", lu_output);
        end
    endtask

    task automatic test_half();
        logic [1:0]  offs [5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
        logic        unss [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps [5] = '{32'hFFFFCCDD, 32'hFFFFAABB, 32'h0000AABB, 32'hFFFFCCDD, 32'hFFFFAABB};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b01, unss[i], 32'hAABBCCDD, offs[i], 1'b0);
            checks++;
            if (lu_output !== exps[i]) begin
                errors++;
                $display("[TB] FAIL half_case%0d got %h expected %h", i, lu_output, exps[i]);
            end
        end
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h7FFF0000, 2'b10, 1'b0);
        checks++;
        if (lu_output !== 32'h00007FFF) begin
            errors++;
            $display("[TB] FAIL half_positive got %h expected 00007fff", lu_output);
        end
    endtask

    task automatic test_word();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i < 4) ? 2'b10 : 2'b11, 1'(i), 32'hAABBCCDD, 2'(i), 1'b0);
            checks++;
            if (lu_output !== 32'hAABBCCDD) begin
                errors++;
                $display("[TB] FAIL word_case%0d got %h expected aabbccdd", i, lu_output);
            end
        end
    endtask

    task automatic test_resp();
        applyStimulus(1'b0, 2'b01, 1'b0, 32'hAABBCCDD, 2'b01, 1'b1);
        checks++;
        if (lu_output !== 32'h0) begin
            errors++;
            $display("[TB] FAIL resp_half got %h expected 00000000", lu_output);
        end
        applyStimulus(1'b0, 2'b11, 1'b0, 32'hAABBCCDD, 2'b11, 1'b1);
        checks++;
        if (lu_output !== 32'h0) begin
            errors++;
            $display("[TB] FAIL resp_word got %h expected 00000000", lu_output);
        end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hAABBCCDD, 2'b00, 1'b0);
        checks++;
        if (lu_output !== 32'hAABBCCDD) begin
            errors++;
            $display("[TB] FAIL resp_recover got %h expected aabbccdd", lu_output);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sizes [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
        logic [1:0]  offs  [6] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
        logic        resps [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps  [6] = '{32'hFFFFFFCC, 32'hFFFFAABB, 32'hAABBCCDD,
                                   32'h00000000, 32'hFFFFCCDD, 32'hAABBCCDD};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, sizes[i], 1'b0, 32'hAABBCCDD, offs[i], resps[i]);
            checks++;
            if (lu_output !== exps[i]) begin
                errors++;
                $display("[TB] FAIL b2b_step%0d got %h expected %h", i, lu_output, exps[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  size;
        logic        uns;
        logic [31:0] data;
        logic [1:0]  off;
        logic        resp;
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            data = $urandom;
            off  = 2'($urandom_range(0, 3));
            resp = ($urandom_range(0, 9) == 0);
            exp  = refModel(size, uns, data, off, resp);
            applyStimulus(1'b0, size, uns, data, off, resp);
            checks++;
            if (lu_output !== exp) begin
                errors++;
                $display("[TB] FAIL random%0d size=%0d uns=%0d data=%h off=%0d resp=%0d got %h expected %h",
                         i, size, uns, data, off, resp, lu_output, exp);
            end
        end
    endtask

    initial begin
        rst_in           = 1'b1;
        load_size_in     = 2'b00;
        load_unsigned_in = 1'b0;
        data_in          = 32'h0;
        iadder_1_to_0_in = 2'b00;
        ahb_resp_in      = 1'b0;
        #2;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_resp();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
